// File: rtl/seq_mult16.sv
// Sequential unsigned N x N -> 2N shift-add multiplier.
// Operands are latched on start, one multiplier bit is consumed per clock, and done flags a held result.
module seq_mult16 #(
   parameter int unsigned N = 16
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           start,
   input  logic [N-1:0]   x1,
   input  logic [N-1:0]   x2,
   output logic [2*N-1:0] out,
   output logic           done
);

   localparam int unsigned CW = $clog2(N);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

   state_t         state;
   state_t         state_next;
   logic [2*N-1:0] a;
   logic [2*N-1:0] acc;
   logic [2*N-1:0] acc_step;
   logic [N-1:0]   b;
   logic [CW-1:0]  cnt;
   logic           last;
   logic           load;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next = state;
      load       = 1'b0;
      acc_step   = b[0] ? acc + a : acc;
      last       = (cnt == CW'(N - 1));
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_next = CALC;
               load       = 1'b1;
            end
         end
         CALC: begin
            if (last) state_next = DONE;
         end
         default: state_next = IDLE;
      endcase
   end

   // out is only written on the final iteration, so it keeps the previous product during CALC.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a    <= '0;
         b    <= '0;
         acc  <= '0;
         cnt  <= '0;
         out  <= '0;
         done <= 1'b0;
      end else if (load) begin
         a    <= {{N{1'b0}}, x1};
         b    <= x2;
         acc  <= '0;
         cnt  <= '0;
         done <= 1'b0;
      end else if (state == CALC) begin
         acc <= acc_step;
         a   <= a << 1;
         b   <= b >> 1;
         cnt <= cnt + CW'(1);
         if (last) begin
            out  <= acc_step;
            done <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: a countdown/product reference model compared every cycle,
// plus directed operations with hand-computed products and latency checks.
module tb_seq_mult16;

   logic        clk;
   logic        rst;
   logic        start;
   logic [15:0] x1;
   logic [15:0] x2;
   logic [31:0] out;
   logic        done;

   int unsigned errors = 0;
   int unsigned checks = 0;

   // reference model: an operation is a product plus a 16-cycle countdown
   logic [31:0] m_out;
   logic        m_done;
   logic [31:0] m_prod;
   int          m_left;

   seq_mult16 #(.N(16)) dut (
      .clk   (clk),
      .rst   (rst),
      .start (start),
      .x1    (x1),
      .x2    (x2),
      .out   (out),
      .done  (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_out  <= '0;
         m_done <= 1'b0;
         m_prod <= '0;
         m_left <= 0;
      end else if (m_left == 0) begin
         if (start) begin
            m_prod <= {16'h0, x1} * {16'h0, x2};
            m_left <= 16;
            m_done <= 1'b0;
         end
      end else begin
         m_left <= m_left - 1;
         if (m_left == 1) begin
            m_out  <= m_prod;
            m_done <= 1'b1;
         end
      end
   end

   always @(negedge clk) begin
      check("cyc_out", out, m_out);
      check("cyc_done", {31'h0, done}, {31'h0, m_done});
   end

   // Launch one operation from IDLE/DONE; optionally scramble start/x1/x2 while it runs.
   task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic [31:0] exp,
                        input bit disturb, input string name);
      logic [31:0] prev;
      int          n;
      bit          got;
      prev  = out;
      x1    = a;
      x2    = b;
      start = 1'b1;
      n     = 0;
      got   = 1'b0;
      while (n < 40 && !got) begin
         @(negedge clk);
         n++;
         got = done;
         if (n == 1) begin
            check({name, "_done_drop"}, {31'h0, done}, 32'h0);
            check({name, "_out_held"}, out, prev);
         end
         if (!got && disturb) begin
            start = 1'($urandom_range(0, 1));
            x1    = 16'($urandom);
            x2    = 16'($urandom);
         end else begin
            start = 1'b0;
         end
      end
      start = 1'b0;
      check({name, "_latency"}, n - 1, 16);
      check({name, "_prod"}, out, exp);
   endtask

   initial begin
      int unsigned pulses;
      logic [15:0] ra;
      logic [15:0] rb;
      rst   = 1'b1;
      start = 1'b0;
      x1    = '0;
      x2    = '0;
      repeat (2) @(negedge clk);
      check("reset_out", out, 32'h0);
      check("reset_done", {31'h0, done}, 32'h0);
      rst = 1'b0;
      @(negedge clk);

      do_op(16'hFA10, 16'hC357, 32'hBECF2B70, 1'b0, "t1");
      check("t1_model", m_out, 32'hBECF2B70);
      repeat (5) @(negedge clk);
      check("t1_hold", out, 32'hBECF2B70);
      check("t1_hold_done", {31'h0, done}, 32'h1);

      do_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0, "t2a");
      do_op(16'h0001, 16'h1234, 32'h00001234, 1'b0, "t2b");
      do_op(16'h0000, 16'hABCD, 32'h00000000, 1'b0, "t3a");
      do_op(16'hABCD, 16'h0000, 32'h00000000, 1'b0, "t3b");
      do_op(16'h1234, 16'h5678, 32'h06260060, 1'b1, "t4");
      do_op(16'h0003, 16'h0005, 32'h0000000F, 1'b0, "t6");

      // asynchronous reset in the middle of an operation
      x1    = 16'h8001;
      x2    = 16'hFFFF;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (8) @(negedge clk);
      #1 rst = 1'b1;
      #1;
      check("t5_out", out, 32'h0);
      check("t5_done", {31'h0, done}, 32'h0);
      @(negedge clk);
      rst = 1'b0;
      repeat (20) @(negedge clk);
      check("t5_idle_done", {31'h0, done}, 32'h0);
      check("t5_idle_out", out, 32'h0);

      // start already high while reset is released
      rst   = 1'b1;
      start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      do_op(16'h0102, 16'h0304, 32'h00030A08, 1'b0, "t7");

      // start held high: back-to-back operations, each done for a single cycle
      x1     = 16'h00FF;
      x2     = 16'h0101;
      start  = 1'b1;
      pulses = 0;
      for (int i = 0; i < 51; i++) begin
         @(negedge clk);
         if (done) pulses++;
      end
      start = 1'b0;
      check("t8_pulses", pulses, 3);
      check("t8_prod", out, 32'h0000FFFF);
      @(negedge clk);

      for (int i = 0; i < 20; i++) begin
         ra = (i % 7 == 0) ? 16'h0 : 16'($urandom);
         rb = (i % 5 == 0) ? 16'hFFFF : 16'($urandom);
         do_op(ra, rb, {16'h0, ra} * {16'h0, rb}, 1'((i % 3) == 0), "rnd");
         repeat ($urandom_range(0, 3)) @(negedge clk);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1);
   end

endmodule
